// File: rtl/spart_pkg.sv
// spart_pkg: receiver state type, oversampling constants and bus ioaddr codes shared across the SPART
package spart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int OVERSAMPLE = 16;
  localparam int HALF_BIT = 8;
  localparam int DATA_BITS = 8;
  // ioaddr codes carry an IO_ prefix so they do not collide with the state names
  localparam logic [1:0] IO_DATA = 2'b00;
  localparam logic [1:0] IO_STATUS = 2'b01;
  localparam logic [1:0] IO_DB_LOW = 2'b10;
  localparam logic [1:0] IO_DB_HIGH = 2'b11;
endpackage

// File: rtl/spart_sync.sv
// spart_sync: N-flop synchronizer for an asynchronous input, resetting to 1 (idle line)
module spart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [N-1:0] r;
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= '1;
    else r <= {r[N-2:0], d};
  assign q = r[N-1];
endmodule

// File: rtl/rx_unit.sv
// rx_unit: 8N1 UART receiver with 16x oversampling, data-available, framing-error and overrun flags
module rx_unit
  import spart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rxd,
  input  logic       clr_rda,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       ferr,
  output logic       ovr
);
  localparam logic [3:0] HALF_LAST = 4'(HALF_BIT - 1);
  localparam logic [3:0] OS_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
  rx_state_t state, state_n;
  logic [3:0] os_cnt, os_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shreg, sh_n, data_n;
  logic rxs, rda_n, ferr_n, ovr_n;
  spart_sync #(.N(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(rxd), .q(rxs));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      os_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      rx_data <= '0;
      rda <= 1'b0;
      ferr <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_n;
      os_cnt <= os_n;
      bit_cnt <= bit_n;
      shreg <= sh_n;
      rx_data <= data_n;
      rda <= rda_n;
      ferr <= ferr_n;
      ovr <= ovr_n;
    end
  // a frame completing in STOP overrides the clear applied below
  always_comb begin
    state_n = state;
    os_n = os_cnt;
    bit_n = bit_cnt;
    sh_n = shreg;
    data_n = rx_data;
    rda_n = clr_rda ? 1'b0 : rda;
    ferr_n = clr_rda ? 1'b0 : ferr;
    ovr_n = clr_rda ? 1'b0 : ovr;
    case (state)
      IDLE:
        if (!rxs) begin
          state_n = START;
          os_n = '0;
        end
      START:
        if (rx_en) begin
          os_n = os_cnt + 4'd1;
          if (os_cnt == HALF_LAST) begin
            state_n = rxs ? IDLE : DATA;
            os_n = '0;
            bit_n = '0;
          end
        end
      DATA:
        if (rx_en) begin
          os_n = os_cnt + 4'd1;
          if (os_cnt == OS_LAST) begin
            sh_n = {rxs, shreg[7:1]};
            bit_n = bit_cnt + 3'd1;
            state_n = (bit_cnt == BIT_LAST) ? STOP : DATA;
          end
        end
      STOP:
        if (rx_en) begin
          os_n = os_cnt + 4'd1;
          if (os_cnt == OS_LAST) begin
            data_n = shreg;
            ferr_n = ~rxs;
            ovr_n = rda & ~clr_rda;
            rda_n = 1'b1;
            state_n = IDLE;
          end
        end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rx_unit.sv
// tb_rx_unit: drives serial frames on rxd and compares outputs with a frame-level reference model
module tb_rx_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_en = 1'b0;
  logic rxd = 1'b1;
  logic clr_rda = 1'b0;
  logic [7:0] rx_data;
  logic rda, ferr, ovr;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_data;
  logic m_rda, m_ferr, m_ovr;
  rx_unit dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rxd(rxd), .clr_rda(clr_rda),
    .rx_data(rx_data), .rda(rda), .ferr(ferr), .ovr(ovr)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".data"}, rx_data, m_data);
    check({tag, ".rda"}, rda, m_rda);
    check({tag, ".ferr"}, ferr, m_ferr);
    check({tag, ".ovr"}, ovr, m_ovr);
  endtask
  task automatic model_reset();
    m_data = 8'h00;
    m_rda = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
  endtask
  // one 16x enable after a random gap long enough for rxd to reach the FSM
  task automatic pulse(input logic clr);
    repeat ($urandom_range(3, 5)) @(negedge clk);
    rx_en = 1'b1;
    clr_rda = clr;
    @(negedge clk);
    rx_en = 1'b0;
    clr_rda = 1'b0;
  endtask
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) pulse(1'b0);
  endtask
  task automatic clear();
    clr_rda = 1'b1;
    @(negedge clk);
    clr_rda = 1'b0;
    m_rda = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    check_all("clr");
  endtask
  // each bit lasts 16 enables; the stop level is held for 8 enables, then the line idles high
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic clr, input int last);
    logic [8:0] f;
    int k;
    f = {b, 1'b0};
    for (int p = 1; p <= last; p++) begin
      k = (p - 1) / 16;
      rxd = (k == 9) ? ((p <= 152) ? stop : 1'b1) : f[k];
      pulse(clr && p == 152);
      if (p == 151) begin
        check("pre.rda", rda, m_rda);
        check("pre.data", rx_data, m_data);
      end
      if (p == 152) begin
        m_ovr = m_rda & ~clr;
        m_rda = 1'b1;
        m_data = b;
        m_ferr = ~stop;
        check_all("done");
      end
    end
    rxd = 1'b1;
  endtask
  initial begin
    logic [7:0] b;
    logic stop, clr;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_all("reset");
    idle(100);
    check_all("idle");
    send_frame(8'hEF, 1'b1, 1'b0, 160);
    clear();
    rxd = 1'b0;
    repeat (4) pulse(1'b0);
    idle(10);
    check_all("false_start");
    send_frame(8'h84, 1'b1, 1'b0, 160);
    clear();
    send_frame(8'h55, 1'b0, 1'b0, 160);
    clear();
    send_frame(8'h12, 1'b1, 1'b0, 160);
    send_frame(8'h34, 1'b1, 1'b0, 160);
    clear();
    send_frame(8'h12, 1'b1, 1'b0, 160);
    send_frame(8'h34, 1'b1, 1'b1, 160);
    send_frame(8'h5A, 1'b1, 1'b0, 88);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("rst_async");
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    check_all("rst_after");
    send_frame(8'hA5, 1'b1, 1'b0, 160);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      clr = 1'($urandom_range(0, 1));
      send_frame(b, stop, clr, 160);
      if ($urandom_range(0, 1) == 1) clear();
      idle($urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_unit.md
# rx_unit

UART receive engine for the SPART, the receiving counterpart of `tx_unit`. It samples the asynchronous `rxd` line using the 16x oversampling enable from `baud_gen`. Each 8N1 frame (start, 8 data bits LSB-first, stop) is assembled into a holding register and reported through a receive-data-available flag, with framing-error and overrun status. It sits beside `tx_unit` inside the SPART and is read by the bus interface at ioaddr DATA/STATUS.

## Interface
- SYNC_STAGES, 2, flip-flops in the `rxd` metastability synchronizer (≥2).
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_en  input  1  one-clk pulse at 16x baud, from `baud_gen` `en`.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- clr_rda  input  1  one-clk strobe from the bus interface: the CPU read rx_data.
- rx_data  output  8  last received byte; held until the next frame completes.
- rda  output  1  receive data available.
- ferr  output  1  framing error: the stop bit was sampled low on the last frame.
- ovr  output  1  overrun: a frame completed while rda was already 1.

## Operation
- `rxd` passes through SYNC_STAGES flops that reset to 1; all logic uses the synchronized value `rxs`.
- Counters:
  - `os_cnt` is 4 bits and advances only on rx_en.
  - `bit_cnt` is 3 bits.
  - `shreg` is 8 bits and shifts right; the new bit enters at [7].
- FSM states IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE: if `rxs`==0 on a clk edge, go to START and clear `os_cnt`.
- START:
  - On rx_en, increment `os_cnt`.
  - When `os_cnt`==7 and rx_en (the 8th enable, mid start bit): if `rxs`==0, go to DATA and clear `os_cnt` and `bit_cnt`.
  - Otherwise it is a false start; return to IDLE and leave the flags untouched.
- DATA:
  - On rx_en, increment `os_cnt`.
  - When `os_cnt`==15 and rx_en (mid-bit), shift `rxs` into `shreg` and increment `bit_cnt`.
  - After the 8th sample (`bit_cnt`==7 at that sample), go to STOP.
- STOP: when `os_cnt`==15 and rx_en (mid stop bit), in the same edge:
  - rx_data ← shreg.
  - ferr ← ~rxs.
  - ovr ← rda & ~clr_rda.
  - rda ← 1.
  - Go to IDLE.
- A frame with a framing error is still delivered. The byte is loaded and rda is set.
- clr_rda, when no frame completes on that edge: clears rda, ferr and ovr. Extra clr_rda strobes with rda==0 are harmless.
- Simultaneous clr_rda and frame completion: completion wins. rda stays 1, ferr reflects the new frame, and ovr=0 because the old byte was read.
- A new start edge is accepted in the first IDLE cycle after STOP. Back-to-back frames with no idle gap are received without loss.
- A `rxs` low during IDLE for less than 8 enables is rejected.
- rx_en is ignored in IDLE.
- Reset mid-frame: everything returns to reset values immediately and the partial frame is discarded.

## Timing
- Reset values:
  - rx_data=8'h00, rda=0, ferr=0, ovr=0.
  - FSM in IDLE.
  - All counters 0; sync flops 1.
- Input latency: SYNC_STAGES clks from a `rxd` transition to `rxs`.
- Frame latency: rda rises on the clk edge of the rx_en pulse that samples the stop bit. That is 8 + 16×9 = 152 rx_en pulses after the start edge is seen in `rxs`.
- All outputs are registered; there is no combinational path from any input to any output.
- The data/flag update and rda are visible together in the same cycle.
- clr_rda takes effect on the edge where it is high; rda reads 0 on the following cycle.

## Structure
- `spart_pkg` holds:
  - `rx_state_t` (IDLE, START, DATA, STOP).
  - `OVERSAMPLE`=16, `HALF_BIT`=8, `DATA_BITS`=8.
  - The ioaddr localparams DATA/STATUS/DB_LOW/DB_HIGH, shared with `tx_unit`.
- One sub-module, `spart_sync`: a parameterized N-flop synchronizer with reset value 1. The FSM, counters and status flags stay in `rx_unit`.

## Test plan
- **Idle:** after reset, hold rxd=1 for 100 rx_en pulses -> rda=0, ferr=0, ovr=0, rx_data=8'h00.
- **Loopback:** tx_unit txd→rxd with a shared baud_gen, transmit 8'hEF -> rda rises 152 rx_en after the start edge, rx_data=8'hEF, ferr=0. Then pulse clr_rda -> rda=0 next cycle.
- **False start:** rxd low for 4 rx_en pulses, then high -> FSM back in IDLE, rda=0. A following valid 8'h84 frame is received correctly.
- **Framing error:** model drives 8'h55 with the stop bit held 0 -> rx_data=8'h55, rda=1, ferr=1.
- **Overrun and simultaneous clear:**
  - Send 8'h12 then 8'h34 without clr_rda -> rx_data=8'h34, ovr=1.
  - Repeat with clr_rda asserted exactly on the completion edge of 8'h34 -> rda=1, ovr=0.
- **Reset mid-frame:** assert rst during data bit 4 -> outputs at reset values. A full 8'hA5 frame after reset is received with rda=1 and ferr=0.
